// File: rtl/pattern_gen_pkg.sv
// Shared types and constants for the pattern generator.
package pattern_gen_pkg;

  // Default counter/field width; matches the measured-count width of the edge counter.
  localparam int DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_gen_if.sv
// Control/status bundle of the pattern generator.
interface pattern_gen_if
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             enb;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_len;
  logic [WIDTH-1:0] num_pulses;
  logic             wave;
  logic             rise;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] pulses_sent;

  // Controller side: drives the requests and configuration.
  modport master (
    output enb, start, stop, period, high_len, num_pulses,
    input  wave, rise, busy, done, pulses_sent
  );

  // Generator side.
  modport slave (
    input  enb, start, stop, period, high_len, num_pulses,
    output wave, rise, busy, done, pulses_sent
  );

endinterface

// File: rtl/pattern_gen_phase_timer.sv
// Loadable down-counter timing the HIGH and LOW phases; tc flags a zero count.
module pattern_gen_phase_timer
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Reload on phase entry, otherwise count down and park at zero.
  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/pattern_gen.sv
// Pulse-train generator: programmable period, high time and pulse count.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  pattern_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_high;   // clamped high time He
  logic [WIDTH-1:0] cfg_num;
  logic             stop_flag;

  logic             tc;
  logic             tmr_load;
  logic [WIDTH-1:0] tmr_val;
  logic [WIDTH-1:0] he_in;
  logic             degenerate;
  logic             finish;

  // Clamp, degenerate-config and end-of-train decisions plus timer reload value.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    he_in      = (bus.high_len >= bus.period) ? bus.period - ONE : bus.high_len;
    degenerate = (bus.period <= ONE) || (bus.high_len == '0);
    finish     = ((cfg_num != '0) && (bus.pulses_sent == cfg_num)) || stop_flag || bus.stop;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    if (bus.enb) begin
      unique case (state)
        ST_IDLE: if (bus.start && !degenerate) begin
          tmr_load = 1'b1;
          tmr_val  = he_in - ONE;
        end
        ST_HIGH: if (tc) begin
          tmr_load = 1'b1;
          tmr_val  = cfg_period - cfg_high - ONE;
        end
        ST_LOW: if (tc && !finish) begin
          tmr_load = 1'b1;
          tmr_val  = cfg_high - ONE;
        end
        default: ;
      endcase
    end
  end

  pattern_gen_phase_timer #(.WIDTH(WIDTH)) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  // State machine with registered outputs; enb low aborts to IDLE from anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: latched configuration is reset too, so no state ever starts as X.
      state           <= ST_IDLE;
      cfg_period      <= '0;
      cfg_high        <= '0;
      cfg_num         <= '0;
      stop_flag       <= 1'b0;
      bus.wave        <= 1'b0;
      bus.rise        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.pulses_sent <= '0;
    end else if (!bus.enb) begin
      state           <= ST_IDLE;
      stop_flag       <= 1'b0;
      bus.wave        <= 1'b0;
      bus.rise        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.pulses_sent <= '0;
    end else begin
      bus.rise <= 1'b0;
      bus.done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            cfg_period <= bus.period;
            cfg_high   <= he_in;
            cfg_num    <= bus.num_pulses;
            if (degenerate) begin
              state           <= ST_DONE;
              bus.done        <= 1'b1;
              bus.pulses_sent <= '0;
            end else begin
              state           <= ST_HIGH;
              bus.wave        <= 1'b1;
              bus.rise        <= 1'b1;
              bus.busy        <= 1'b1;
              bus.pulses_sent <= ONE;
            end
          end
        end
        ST_HIGH: begin
          if (bus.stop) stop_flag <= 1'b1;
          if (tc) begin
            state    <= ST_LOW;
            bus.wave <= 1'b0;
          end
        end
        ST_LOW: begin
          if (bus.stop) stop_flag <= 1'b1;
          if (tc) begin
            if (finish) begin
              state    <= ST_DONE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end else begin
              state           <= ST_HIGH;
              bus.wave        <= 1'b1;
              bus.rise        <= 1'b1;
              bus.pulses_sent <= bus.pulses_sent + ONE;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          stop_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: vector table plus multi-cycle corner cases.
module tb_pattern_gen;

  localparam int W = 12;

  typedef struct {
    logic         wave;
    logic         rise;
    logic         busy;
    logic         done;
    logic [W-1:0] ps;
  } exp_t;

  typedef struct {
    int p;
    int h;
    int n;
    int exp_ps;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[9];

  // Edge counter fed by the generated waveform.
  int   edge_cnt = 0;
  logic wave_q   = 1'b0;

  pattern_gen_if #(.WIDTH(W)) bus ();

  pattern_gen #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wave && !wave_q) edge_cnt++;
    wave_q = bus.wave;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected per-cycle outputs from the cycle after start through the done strobe.
  function automatic void push_train(input int p, input int h, input int n);
    int he;
    if (p <= 1 || h == 0) begin
      sb.push_back('{wave: 1'b0, rise: 1'b0, busy: 1'b0, done: 1'b1, ps: '0});
      return;
    end
    he = (h >= p) ? p - 1 : h;
    for (int k = 1; k <= n; k++)
      for (int c = 0; c < p; c++)
        sb.push_back('{wave: (c < he), rise: (c == 0), busy: 1'b1, done: 1'b0, ps: W'(k)});
    sb.push_back('{wave: 1'b0, rise: 1'b0, busy: 1'b0, done: 1'b1, ps: W'(n)});
  endfunction

  task automatic compare_next(input string tag);
    exp_t e;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " wave"}, 32'(bus.wave), 32'(e.wave));
      check({tag, " rise"}, 32'(bus.rise), 32'(e.rise));
      check({tag, " busy"}, 32'(bus.busy), 32'(e.busy));
      check({tag, " done"}, 32'(bus.done), 32'(e.done));
      check({tag, " pulses_sent"}, 32'(bus.pulses_sent), 32'(e.ps));
    end
  endtask

  task automatic check_idle(input string tag, input int exp_ps);
    check({tag, " idle wave"}, 32'(bus.wave), 0);
    check({tag, " idle rise"}, 32'(bus.rise), 0);
    check({tag, " idle busy"}, 32'(bus.busy), 0);
    check({tag, " idle done"}, 32'(bus.done), 0);
    check({tag, " idle pulses_sent"}, 32'(bus.pulses_sent), 32'(exp_ps));
  endtask

  // Drive one train; a late start with degenerate config is injected to prove it is ignored.
  task automatic run_train(input int p, input int h, input int n_in, input int n_model,
                           input int stop_at, input int exp_ps, input string tag);
    int idx = 0;
    bus.period     = W'(p);
    bus.high_len   = W'(h);
    bus.num_pulses = W'(n_in);
    bus.start      = 1'b1;
    push_train(p, h, n_model);
    while (sb.size() > 0) begin
      compare_next(tag);
      if (idx == 0) begin
        bus.start      = 1'b1;
        bus.period     = W'(1);
        bus.high_len   = '0;
        bus.num_pulses = W'(1);
      end else begin
        bus.start = 1'b0;
      end
      bus.stop = (idx == stop_at);
      idx++;
    end
    @(negedge clk);
    check_idle(tag, exp_ps);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    int base;
    int rises;
    bit seen;

    vecs[0] = '{p: 5, h: 2, n: 3, exp_ps: 3};
    vecs[1] = '{p: 4, h: 7, n: 1, exp_ps: 1};
    vecs[2] = '{p: 0, h: 3, n: 2, exp_ps: 0};
    vecs[3] = '{p: 5, h: 0, n: 2, exp_ps: 0};
    vecs[4] = '{p: 1, h: 1, n: 1, exp_ps: 0};
    vecs[5] = '{p: 3, h: 1, n: 2, exp_ps: 2};
    vecs[6] = '{p: 2, h: 1, n: 1, exp_ps: 1};
    vecs[7] = '{p: 6, h: 5, n: 2, exp_ps: 2};
    vecs[8] = '{p: 4, h: 4, n: 2, exp_ps: 2};

    rst_n          = 1'b0;
    bus.enb        = 1'b1;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.period     = '0;
    bus.high_len   = '0;
    bus.num_pulses = '0;
    #12;
    check_idle("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset", 0);

    // start with enb low is not accepted
    bus.enb   = 1'b0;
    bus.start = 1'b1;
    bus.period = W'(5); bus.high_len = W'(2); bus.num_pulses = W'(1);
    @(negedge clk);
    check_idle("enb_low_start", 0);
    bus.start = 1'b0;
    bus.enb   = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_train(vecs[i].p, vecs[i].h, vecs[i].n, vecs[i].n, -1, vecs[i].exp_ps,
                $sformatf("vec%0d", i));

    // Continuous mode, stop during the 2nd cycle of pulse 4.
    run_train(3, 1, 0, 4, 10, 4, "stop");

    // enb dropped in the first HIGH cycle of pulse 2.
    bus.period = W'(5); bus.high_len = W'(3); bus.num_pulses = W'(4);
    bus.start  = 1'b1;
    push_train(5, 3, 4);
    for (int i = 0; i < 6; i++) begin
      compare_next("enb_abort");
      bus.start = 1'b0;
    end
    bus.enb = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("enb_abort", 0);
    end
    bus.enb = 1'b1;
    @(negedge clk);

    // Asynchronous reset pulse during LOW of pulse 1.
    bus.period = W'(5); bus.high_len = W'(2); bus.num_pulses = W'(3);
    bus.start  = 1'b1;
    push_train(5, 2, 3);
    for (int i = 0; i < 4; i++) begin
      compare_next("rst_abort");
      bus.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check_idle("rst_async", 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("rst_abort", 0);
    end

    // Operation resumes after reset.
    run_train(5, 2, 3, 3, -1, 3, "after_rst");

    // Loopback into the edge counter.
    base = edge_cnt;
    run_train(6, 3, 10, 10, -1, 10, "loop");
    check("loop edge_cnt", 32'(edge_cnt - base), 10);

    // pulses_sent wraps in continuous mode without ending the train.
    bus.period = W'(2); bus.high_len = W'(1); bus.num_pulses = '0;
    bus.start  = 1'b1;
    rises = 0;
    for (int cyc = 0; cyc < 9000 && rises < 4097; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.rise) rises++;
    end
    check("wrap rises", 32'(rises), 4097);
    check("wrap pulses_sent", 32'(bus.pulses_sent), 1);
    check("wrap busy", 32'(bus.busy), 1);
    bus.stop = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      bus.stop = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        check("wrap done pulses_sent", 32'(bus.pulses_sent), 1);
      end
    end
    check("wrap done seen", 32'(seen), 1);
    @(negedge clk);
    check_idle("wrap", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter: WIDTH, default 12, bit width of the period, high-time and pulse-count fields and counters.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: enb  input  1  active-high enable; low forces an abort to IDLE.
REQ-005 Port: start  input  1  single-cycle request to begin a pulse train; sampled in IDLE only.
REQ-006 Port: stop  input  1  request to end the train at the next period boundary.
REQ-007 Port: period  input  WIDTH  full period P in clk cycles; latched at accepted start.
REQ-008 Port: high_len  input  WIDTH  high time H in clk cycles; latched at accepted start.
REQ-009 Port: num_pulses  input  WIDTH  pulse count N; 0 means run continuously; latched at accepted start.
REQ-010 Port: wave  output  1  registered generated waveform.
REQ-011 Port: rise  output  1  registered one-cycle strobe in the first cycle of each high phase.
REQ-012 Port: busy  output  1  high in HIGH and LOW states.
REQ-013 Port: done  output  1  one-cycle strobe on normal completion.
REQ-014 Port: pulses_sent  output  WIDTH  number of rise strobes issued in the current or last train.

Function
REQ-015 FSM states: IDLE, HIGH, LOW, DONE; encoding binary, registered.
REQ-016 IDLE: start=1 with enb=1 latches P, H and N, clears pulses_sent, and enters HIGH next cycle.
REQ-017 Effective high time He = H, clamped to P-1 when H >= P, so LOW always lasts at least 1 cycle.
REQ-018 Accepted start with P=0, P=1 or H=0 enters DONE directly: no rise strobe and pulses_sent=0.
REQ-019 HIGH: wave=1 for exactly He cycles; rise=1 only in the first HIGH cycle; pulses_sent increments in that same cycle.
REQ-020 LOW: wave=0 for exactly P-He cycles; rise is the first-cycle strobe of HIGH and is first visible 1 cycle after the accepted start.
REQ-021 End of LOW: if N!=0 and pulses_sent==N, or stop was seen during the period, go to DONE; otherwise go to HIGH.
REQ-022 stop is captured in a sticky flag at any cycle while busy; the flag clears on entry to IDLE.
REQ-023 DONE lasts 1 cycle: done=1, wave=0, busy=0; then IDLE.
REQ-024 pulses_sent holds its value in IDLE until the next accepted start.
REQ-025 pulses_sent wraps modulo 2^WIDTH in continuous mode (N=0); this does not terminate the train.
REQ-026 start while busy or in DONE is ignored; input changes to P, H and N while busy are ignored.
REQ-027 enb=0 in any state: next cycle IDLE, wave=0, rise=0, busy=0, done not asserted, pulses_sent cleared.
REQ-028 Phase counter is WIDTH bits, reloaded at each phase entry; there is no combinational path from inputs to outputs.

Reset
REQ-029 rst_n low asynchronously forces IDLE, wave=0, rise=0, busy=0, done=0, pulses_sent=0, stop flag=0 and the latched config to 0.
REQ-030 Reset asserted mid-train aborts immediately with no done strobe; operation resumes on the first edge after deassertion, with start sampled then.

Structure
REQ-031 A shared package holds the FSM state typedef and the default WIDTH constant (12), matching the measured-count width of the edge counter.
REQ-032 Sub-module phase_timer: a loadable WIDTH-bit down-counter with a terminal-count flag, instantiated once for the HIGH and LOW phase timing.

Verification
REQ-033 P=5, H=2, N=3, start pulse -> wave 11000 repeated 3 times, 3 rise strobes 5 cycles apart, done 1 cycle after the last LOW cycle, pulses_sent=3.
REQ-034 P=4, H=7, N=1 -> wave high 3 cycles then low 1 cycle, then done; pulses_sent=1.
REQ-035 P=0 or H=0, start -> done the cycle after start, no rise, pulses_sent=0.
REQ-036 N=0, P=3, H=1, stop asserted in the 2nd cycle of pulse 4 -> pulse 4 completes, done, pulses_sent=4.
REQ-037 enb dropped during HIGH of pulse 2, and in a separate run rst_n pulsed low during LOW -> wave=0 and busy=0 immediately, no done, pulses_sent=0.
REQ-038 Loopback: wave feeding the team's edge counter (enb held high) for P=6, H=3, N=10 -> the counter reads 10 after done.
